gcn_combination: RTL and testbench

- Aggregation-plus-classification stage of the GCN datapath. Sits directly downstream of the feature×weight transformation stage.
- Takes the transformed matrix FM·W (FEATURE_ROWS × WEIGHT_COLS), walks the COO edge list, and accumulates neighbour rows per node (A·FM·W).
- Produces a per-node argmax class index on max_addi_answer.
- Drives the COO read address and the GCN-level done.

---
 rtl/gcn_pkg.sv | 45 ++++
 rtl/gcn_argmax_row.sv | 34 +++
 rtl/gcn_combination.sv | 148 ++++++++++++++
 tb/tb_gcn_combination.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// ============================================================================
// Module  : gcn_pkg
// Brief   : Shared constants, typedefs and the row-add helper for the GCN
//           combination (aggregation + argmax) stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gcn_pkg;

  localparam int FEATURE_ROWS      = 6;
  localparam int WEIGHT_COLS       = 3;
  localparam int DOT_PROD_WIDTH    = 16;
  localparam int NUM_OF_NODES      = 6;
  localparam int COO_NUM_OF_COLS   = 6;
  localparam int COO_NUM_OF_ROWS   = 2;
  localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
  localparam int MAX_ADDRESS_WIDTH = 2;
  localparam int ROW_CNT_W         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

  // One row of FM*W (or of an accumulator): WEIGHT_COLS unsigned elements.
  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_wm_row_t;

  // One COO edge: [0] = source node, [1] = destination node.
  typedef logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0] coo_edge_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDGE   = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } gcn_state_e;

  // Element-wise add of two rows; each lane wraps modulo 2^DOT_PROD_WIDTH.
  function automatic fm_wm_row_t row_add(input fm_wm_row_t a, input fm_wm_row_t b);
    fm_wm_row_t sum;
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      sum[c] = a[c] + b[c];
    end
    return sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcn_argmax_row.sv
// ============================================================================
// Module  : gcn_argmax_row
// Brief   : Combinational COLS-way unsigned argmax. A strict greater-than scan
//           from column 0 means ties resolve to the lowest column index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_argmax_row #(
  parameter int COLS  = 3,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic [0:COLS-1][WIDTH-1:0] i_row,
  output logic [IDX_W-1:0]           o_idx
);

  logic [WIDTH-1:0] w_best;

  // Running maximum; only a strictly larger value moves the winning index.
  always_comb begin
    w_best = i_row[0];
    o_idx  = '0;
    for (int c = 1; c < COLS; c++) begin
      if (i_row[c] > w_best) begin
        w_best = i_row[c];
        o_idx  = IDX_W'(c);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcn_combination.sv
// ============================================================================
// Module  : gcn_combination
// Brief   : Walks the COO edge list accumulating neighbour rows of FM*W per
//           node (A*FM*W), then emits a per-node argmax class index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_combination
  import gcn_pkg::*;
(
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       start,
  input  logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_wm_in,
  input  logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]                     coo_in,
  output logic [COO_BW-1:0]                                          coo_address,
  output logic                                                       done,
  output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]             max_addi_answer
);

  localparam logic [1:0] c_ST_IDLE   = IDLE;
  localparam logic [1:0] c_ST_EDGE   = EDGE;
  localparam logic [1:0] c_ST_ARGMAX = ARGMAX;
  localparam logic [1:0] c_ST_DONE   = DONE;

  // Node bound is one bit wider than an index so NUM_OF_NODES == 2^COO_BW still works.
  localparam logic [COO_BW:0]    c_NUM_NODES = (COO_BW+1)'(NUM_OF_NODES);
  localparam logic [COO_BW-1:0]  c_LAST_ADDR = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [ROW_CNT_W-1:0] c_LAST_ROW = ROW_CNT_W'(FEATURE_ROWS - 1);

  logic [1:0]                                   r_state;
  logic [COO_BW-1:0]                            r_coo_addr;
  logic                                         r_done;
  logic [ROW_CNT_W-1:0]                         r_row;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] r_answer;
  fm_wm_row_t                                   r_fm  [0:FEATURE_ROWS-1];
  fm_wm_row_t                                   r_acc [0:FEATURE_ROWS-1];

  fm_wm_row_t                                   w_acc_nxt [0:FEATURE_ROWS-1];
  coo_edge_t                                    w_edge;
  logic [COO_BW-1:0]                            w_src;
  logic [COO_BW-1:0]                            w_dst;
  logic                                         w_edge_ok;
  logic                                         w_self;
  logic                                         w_last_edge;
  logic                                         w_last_row;
  logic [MAX_ADDRESS_WIDTH-1:0]                 w_max_idx;

  assign w_edge      = coo_in;
  assign w_src       = w_edge[0];
  assign w_dst       = w_edge[1];
  assign w_edge_ok   = ({1'b0, w_src} < c_NUM_NODES) && ({1'b0, w_dst} < c_NUM_NODES);
  assign w_self      = (w_src == w_dst);
  // The address register also serves as the index of the edge currently on coo_in.
  assign w_last_edge = (r_coo_addr == c_LAST_ADDR);
  assign w_last_row  = (r_row == c_LAST_ROW);

  assign coo_address     = r_coo_addr;
  assign done            = r_done;
  assign max_addi_answer = r_answer;

  // Next accumulator values for the edge on coo_in; a self-loop adds its row only once.
  always_comb begin
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      w_acc_nxt[r] = r_acc[r];
      if (w_edge_ok) begin
        if (COO_BW'(r) == w_src) begin
          w_acc_nxt[r] = row_add(w_acc_nxt[r], r_fm[w_dst]);
        end
        if ((COO_BW'(r) == w_dst) && !w_self) begin
          w_acc_nxt[r] = row_add(w_acc_nxt[r], r_fm[w_src]);
        end
      end
    end
  end

  // Single argmax unit, time-shared across rows by the ARGMAX row counter.
  gcn_argmax_row #(
    .COLS  (WEIGHT_COLS),
    .WIDTH (DOT_PROD_WIDTH),
    .IDX_W (MAX_ADDRESS_WIDTH)
  ) u_argmax (
    .i_row (r_acc[r_row]),
    .o_idx (w_max_idx)
  );

  // Control FSM plus the captured matrix, accumulators and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_ST_IDLE;
      r_coo_addr <= '0;
      r_done     <= 1'b0;
      r_row      <= '0;
      r_answer   <= '0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        r_fm[r]  <= '0;
        r_acc[r] <= '0;
      end
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            for (int r = 0; r < FEATURE_ROWS; r++) begin
              r_fm[r]  <= fm_wm_in[r];
              r_acc[r] <= '0;
            end
            r_answer   <= '0;
            r_coo_addr <= '0;
            r_row      <= '0;
            r_state    <= c_ST_EDGE;
          end
        end
        c_ST_EDGE: begin
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            r_acc[r] <= w_acc_nxt[r];
          end
          if (w_last_edge) begin
            r_row   <= '0;
            r_state <= c_ST_ARGMAX;
          end else begin
            r_coo_addr <= r_coo_addr + 1'b1;
          end
        end
        c_ST_ARGMAX: begin
          r_answer[r_row] <= w_max_idx;
          if (w_last_row) begin
            r_done  <= 1'b1;
            r_state <= c_ST_DONE;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        c_ST_DONE: begin
          // Results are held; dropping start re-arms without clearing them.
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gcn_combination.sv
// ============================================================================
// Module  : tb_gcn_combination
// Brief   : Directed self-checking bench for gcn_combination.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcn_combination;
  import gcn_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_wm_in;
  logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]                     coo_in;
  logic [COO_BW-1:0]                                          coo_address;
  logic                                                       done;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]             max_addi_answer;

  coo_edge_t coo_tbl [0:COO_NUM_OF_COLS-1];
  logic [COO_BW-1:0] addr_seen [0:COO_NUM_OF_COLS-1];
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] exp_ring;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] exp_ans;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Edge memory with combinational read of the registered address.
  assign coo_in = coo_tbl[coo_address];

  gcn_combination dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .fm_wm_in        (fm_wm_in),
    .coo_in          (coo_in),
    .coo_address     (coo_address),
    .done            (done),
    .max_addi_answer (max_addi_answer)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // fm row i: 10 at column i mod 3, 1 elsewhere.
  task automatic load_ring_fm();
    for (int i = 0; i < FEATURE_ROWS; i++)
      for (int c = 0; c < WEIGHT_COLS; c++)
        fm_wm_in[i][c] = (c == (i % 3)) ? 16'd10 : 16'd1;
  endtask

  task automatic load_ring_edges();
    for (int j = 0; j < COO_NUM_OF_COLS; j++) begin
      coo_tbl[j][0] = COO_BW'(j);
      coo_tbl[j][1] = COO_BW'((j + 1) % NUM_OF_NODES);
    end
  endtask

  // Raise start and count edges after the start-sampling edge until done (-1 on timeout).
  task automatic run_job(input bit disturb, output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n < COO_NUM_OF_COLS) addr_seen[n] = coo_address;
      if (disturb && n == 0) fm_wm_in = '1;
      if (disturb && n == 2) start = 1'b0;
      if (disturb && n == 8) start = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_job();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    fm_wm_in = '0;
    load_ring_edges();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (coo_address !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", coo_address); end
    checks++;
    if (max_addi_answer !== '0) begin failures++; $display("FAIL reset_answer got=%h want=0", max_addi_answer); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ring_latency();
    int lat;
    load_ring_fm();
    load_ring_edges();
    run_job(1'b0, lat);
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL ring_latency got=%0d want=12", lat); end
    for (int k = 0; k < COO_NUM_OF_COLS; k++) begin
      checks++;
      if (addr_seen[k] !== COO_BW'(k)) begin
        failures++;
        $display("FAIL ring_coo_addr[%0d] got=%0d want=%0d", k, addr_seen[k], k);
      end
    end
    checks++;
    if (max_addi_answer !== exp_ring) begin
      failures++;
      $display("FAIL ring_answer got=%h want=%h", max_addi_answer, exp_ring);
    end
  endtask

  // Continues from DONE of the ring run with start still high.
  task automatic test_handshake();
    int lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || max_addi_answer !== exp_ring || coo_address !== c_addr_last()) begin
        failures++;
        $display("FAIL hold_done cyc=%0d got done=%b ans=%h addr=%0d want done=1 ans=%h addr=%0d",
                 i, done, max_addi_answer, coo_address, exp_ring, c_addr_last());
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL drop_start_done got=%b want=0", done); end
    checks++;
    if (max_addi_answer !== exp_ring) begin
      failures++;
      $display("FAIL drop_start_kept got=%h want=%h", max_addi_answer, exp_ring);
    end
    run_job(1'b0, lat);
    checks++;
    if (lat !== 12 || max_addi_answer !== exp_ring) begin
      failures++;
      $display("FAIL rerun got lat=%0d ans=%h want lat=12 ans=%h", lat, max_addi_answer, exp_ring);
    end
    finish_job();
  endtask

  function automatic logic [COO_BW-1:0] c_addr_last();
    return COO_BW'(COO_NUM_OF_COLS - 1);
  endfunction

  task automatic test_all_zero();
    int lat;
    fm_wm_in = '0;
    load_ring_edges();
    run_job(1'b0, lat);
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL zero_latency got=%0d want=12", lat); end
    checks++;
    if (max_addi_answer !== '0) begin failures++; $display("FAIL zero_answer got=%h want=0", max_addi_answer); end
    finish_job();
  endtask

  task automatic test_invalid_self_loop();
    int lat;
    for (int i = 0; i < FEATURE_ROWS; i++) begin
      fm_wm_in[i][0] = 16'd1; fm_wm_in[i][1] = 16'd2; fm_wm_in[i][2] = 16'd3;
    end
    fm_wm_in[2][0] = 16'd3; fm_wm_in[2][1] = 16'd9; fm_wm_in[2][2] = 16'd4;
    for (int j = 0; j < COO_NUM_OF_COLS - 1; j++) begin
      coo_tbl[j][0] = COO_BW'(7);
      coo_tbl[j][1] = COO_BW'(0);
    end
    coo_tbl[COO_NUM_OF_COLS-1][0] = COO_BW'(2);
    coo_tbl[COO_NUM_OF_COLS-1][1] = COO_BW'(2);
    exp_ans = '0;
    exp_ans[2] = 2'd1;
    run_job(1'b0, lat);
    checks++;
    if (lat !== 12 || max_addi_answer !== exp_ans) begin
      failures++;
      $display("FAIL invalid_selfloop got lat=%0d ans=%h want lat=12 ans=%h", lat, max_addi_answer, exp_ans);
    end
    finish_job();
  endtask

  // Also disturbs fm_wm_in and start after capture; neither may matter.
  task automatic test_wrap();
    int lat;
    fm_wm_in = '0;
    fm_wm_in[1][0] = 16'h8000;
    fm_wm_in[1][1] = 16'h0001;
    for (int j = 0; j < COO_NUM_OF_COLS; j++) begin
      coo_tbl[j][0] = COO_BW'(0);
      coo_tbl[j][1] = COO_BW'(1);
    end
    exp_ans = '0;
    exp_ans[0] = 2'd1;
    run_job(1'b1, lat);
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL wrap_latency got=%0d want=12", lat); end
    checks++;
    if (max_addi_answer !== exp_ans) begin
      failures++;
      $display("FAIL wrap_answer got=%h want=%h", max_addi_answer, exp_ans);
    end
    finish_job();
  endtask

  task automatic test_reset_mid();
    int lat;
    load_ring_fm();
    load_ring_edges();
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 4; n++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || coo_address !== '0 || max_addi_answer !== '0) begin
      failures++;
      $display("FAIL reset_mid got done=%b addr=%0d ans=%h want 0/0/0", done, coo_address, max_addi_answer);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || coo_address !== '0) begin
      failures++;
      $display("FAIL reset_mid_idle got done=%b addr=%0d want 0/0", done, coo_address);
    end
    run_job(1'b0, lat);
    checks++;
    if (lat !== 12 || max_addi_answer !== exp_ring) begin
      failures++;
      $display("FAIL reset_mid_rerun got lat=%0d ans=%h want lat=12 ans=%h", lat, max_addi_answer, exp_ring);
    end
    finish_job();
  endtask

  initial begin
    exp_ring    = '0;
    exp_ring[0] = 2'd1;
    exp_ring[3] = 2'd1;
    exp_ans     = '0;
    test_reset();
    test_ring_latency();
    test_handshake();
    test_all_zero();
    test_invalid_self_loop();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
